// File: rtl/trigger_pkg.sv
// Shared encodings for the trigger/capture stage: FSM states, trigger modes, slope select.
package trigger_pkg;
  typedef logic [2:0] state_t;
  typedef logic [1:0] mode_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t PREFILL   = 3'd1;
  localparam state_t WAIT_TRIG = 3'd2;
  localparam state_t POSTFILL  = 3'd3;
  localparam state_t DONE      = 3'd4;

  localparam mode_t MODE_AUTO   = 2'd0;
  localparam mode_t MODE_NORMAL = 2'd1;
  localparam mode_t MODE_SINGLE = 2'd2;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;
endpackage

// File: rtl/trig_frame_ram.sv
// Two frame buffers in one simple dual-port RAM; address = {buffer_sel, index}.
module trig_frame_ram #(
  parameter int DATA_W = 12,
  parameter int AW     = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  // Power-of-two sized: the concatenated address leaves a hole above DEPTH in each half.
  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/trigger_capture.sv
// Edge-triggered, double-buffered frame capture between the ADC and the display column reader.
module trigger_capture import trigger_pkg::*; #(
  parameter int DATA_W       = 12,
  parameter int X_W          = 11,
  parameter int DEPTH        = 640,
  parameter int PRETRIG      = 64,
  parameter int AUTO_TIMEOUT = 1048576
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [7:0]        decim,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [1:0]        trig_mode,
  input  logic              arm,
  input  logic              frame_start,
  input  logic [X_W-1:0]    screenX,
  output logic [DATA_W-1:0] screenData,
  output logic              resample,
  output logic              triggered,
  output logic              busy
);
  localparam int IW   = $clog2(DEPTH);
  localparam int SW   = X_W + 1;
  localparam int POST = DEPTH - PRETRIG;
  localparam int PW   = $clog2(DEPTH + 1);
  localparam int TW   = $clog2(AUTO_TIMEOUT + 1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [7:0]        dec_q;
  logic [IW-1:0]     wptr_q;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0] prev_q;
  logic [IW-1:0]     base_q, base_d;
  logic              flag_q, flag_d;
  logic              front_sel_q, front_valid_q, trig_q, resample_q, rd_ok_q;
  logic [IW-1:0]     front_base_q;

  logic              kept, capturing, we, hit, swap, in_range;
  logic [SW-1:0]     bsum, rsum;
  logic [IW-1:0]     base_w, ridx;
  logic [DATA_W-1:0] rdata;

  assign kept      = sample_valid && (dec_q == 8'd0);
  assign capturing = state_q inside {PREFILL, WAIT_TRIG, POSTFILL};
  assign we        = kept && capturing;
  assign hit       = (trig_slope == SLOPE_RISE) ? (prev_q < trig_level && sample_in >= trig_level)
                                                : (prev_q > trig_level && sample_in <= trig_level);

  // (wptr - PRETRIG) mod DEPTH, computed as wptr + POST with one conditional subtract.
  assign bsum   = SW'(wptr_q) + SW'(POST);
  assign base_w = (bsum >= SW'(DEPTH)) ? IW'(bsum - SW'(DEPTH)) : IW'(bsum);

  assign rsum     = SW'(front_base_q) + SW'(screenX);
  assign ridx     = (rsum >= SW'(DEPTH)) ? IW'(rsum - SW'(DEPTH)) : IW'(rsum);
  assign in_range = SW'(screenX) < SW'(DEPTH);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    base_d  = base_q;
    flag_d  = flag_q;
    swap    = 1'b0;
    case (state_q)
      IDLE: if (trig_mode != MODE_SINGLE || arm) begin
        state_d = PREFILL;
        mode_d  = (trig_mode == 2'd3) ? MODE_NORMAL : trig_mode;
        cnt_d   = '0;
      end
      PREFILL: if (we) begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == PW'(PRETRIG - 1)) begin
          state_d = WAIT_TRIG;
          tmo_d   = '0;
        end
      end
      WAIT_TRIG: begin
        tmo_d = tmo_q + TW'(1);
        if (we && hit) begin
          base_d  = base_w;
          flag_d  = 1'b1;
          cnt_d   = PW'(1);
          state_d = (POST == 1) ? DONE : POSTFILL;
        end else if (mode_q == MODE_AUTO && tmo_q == TW'(AUTO_TIMEOUT - 1)) begin
          // A sample kept on the timeout cycle is already in the frame, so it counts as write 1.
          base_d  = base_w;
          flag_d  = 1'b0;
          cnt_d   = we ? PW'(1) : PW'(0);
          state_d = (we && POST == 1) ? DONE : POSTFILL;
        end
      end
      POSTFILL: if (we) begin
        cnt_d = cnt_q + PW'(1);
        if (cnt_q == PW'(POST - 1)) state_d = DONE;
      end
      DONE: if (frame_start) begin
        swap    = 1'b1;
        mode_d  = (trig_mode == 2'd3) ? MODE_NORMAL : trig_mode;
        state_d = (trig_mode == MODE_SINGLE) ? IDLE : PREFILL;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= MODE_AUTO;
      dec_q         <= '0;
      wptr_q        <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      prev_q        <= '0;
      base_q        <= '0;
      flag_q        <= 1'b0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      front_base_q  <= '0;
      trig_q        <= 1'b0;
      resample_q    <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      base_q     <= base_d;
      flag_q     <= flag_d;
      resample_q <= swap;
      rd_ok_q    <= front_valid_q && in_range;
      if (sample_valid) dec_q <= (dec_q >= decim) ? 8'd0 : dec_q + 8'd1;
      if (we) begin
        wptr_q <= (wptr_q == IW'(DEPTH - 1)) ? '0 : wptr_q + IW'(1);
        prev_q <= sample_in;
      end
      if (swap) begin
        front_sel_q   <= ~front_sel_q;
        front_base_q  <= base_q;
        trig_q        <= flag_q;
        front_valid_q <= 1'b1;
      end
    end
  end

  trig_frame_ram #(.DATA_W(DATA_W), .AW(IW + 1)) u_ram (
    .clk_i  (clock),
    .we_i   (we),
    .waddr_i({~front_sel_q, wptr_q}),
    .wdata_i(sample_in),
    .raddr_i({front_sel_q, ridx}),
    .rdata_o(rdata)
  );

  assign screenData = rd_ok_q ? rdata : '0;
  assign resample   = resample_q;
  assign triggered  = trig_q;
  assign busy       = capturing;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed + randomized bench for trigger_capture against a kept-sample-stream reference model.
module tb_trigger_capture;
  localparam int DATA_W  = 12;
  localparam int X_W     = 11;
  localparam int DEPTH   = 640;
  localparam int PRETRIG = 64;
  localparam int AUTO_TO = 1000;

  logic              clock = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [7:0]        decim;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [1:0]        trig_mode;
  logic              arm;
  logic              frame_start;
  logic [X_W-1:0]    screenX;
  logic [DATA_W-1:0] screenData;
  logic              resample, triggered, busy;

  trigger_capture #(
    .DATA_W(DATA_W), .X_W(X_W), .DEPTH(DEPTH), .PRETRIG(PRETRIG), .AUTO_TIMEOUT(AUTO_TO)
  ) dut (
    .clock(clock), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .decim(decim), .trig_level(trig_level), .trig_slope(trig_slope), .trig_mode(trig_mode),
    .arm(arm), .frame_start(frame_start), .screenX(screenX), .screenData(screenData),
    .resample(resample), .triggered(triggered), .busy(busy)
  );

  always #5 clock = ~clock;

  int nvec, nfail, vcnt, trig_idx, tgt;
  int hist[$];
  bit rec, cap_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the kept stream of one capture; first edge at index >= PRETRIG defines the frame.
  function automatic void push_kept(input int v);
    int n, lvl;
    hist.push_back(v);
    n = hist.size();
    lvl = int'(trig_level);
    if (trig_idx < 0 && n - 1 >= PRETRIG) begin
      int p = hist[n-2];
      if (trig_slope ? (p > lvl && v <= lvl) : (p < lvl && v >= lvl)) begin
        trig_idx = n - 1;
        tgt = trig_idx + DEPTH - PRETRIG;
      end
    end
    if (trig_idx >= 0 && n == tgt) begin
      rec = 1'b0;
      cap_done = 1'b1;
    end
  endfunction

  function automatic bit will_keep();
    return sample_valid && !reset && (vcnt % (int'(decim) + 1) == 0);
  endfunction

  task automatic tick();
    bit k;
    k = will_keep();
    if (reset) vcnt = 0;
    else if (sample_valid) vcnt++;
    if (rec && k) push_kept(int'(sample_in));
    @(posedge clock);
    #1;
  endtask

  task automatic start_capture();
    hist.delete();
    trig_idx = -1;
    cap_done = 1'b0;
    rec = 1'b1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset = 1'b1; sample_valid = 1'b0; arm = 1'b0; frame_start = 1'b0;
    trig_mode = m; rec = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // kind: 0 ramp, 1 square 3000/500, 2 random with gaps
  task automatic run_capture(input int kind, input bit coinc, input int stop_post, input int max_ticks);
    int n;
    bit fs;
    n = 0;
    while (!cap_done && n < max_ticks) begin
      if (stop_post > 0 && trig_idx >= 0 && hist.size() >= trig_idx + stop_post) break;
      sample_valid = (kind == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (kind)
        0:       sample_in = DATA_W'(n);
        1:       sample_in = ((n / 37) % 2 == 0) ? DATA_W'(3000 + n % 8) : DATA_W'(500 + n % 8);
        default: sample_in = DATA_W'($urandom_range(0, 4095));
      endcase
      fs = coinc && trig_idx >= 0 && hist.size() == tgt - 1 && will_keep();
      frame_start = fs;
      tick();
      if (fs) check("coinc_no_resample", resample, 0);
      n++;
    end
    sample_valid = 1'b0;
    frame_start = 1'b0;
    if (stop_post == 0) check("capture_complete", cap_done, 1);
  endtask

  task automatic read_cols(input int cval);
    int cols[$];
    int e;
    cols = {0, PRETRIG, DEPTH - 1, 700};
    repeat (4) cols.push_back($urandom_range(0, DEPTH - 1));
    foreach (cols[i]) begin
      screenX = X_W'(cols[i]);
      tick();
      if (cols[i] >= DEPTH) e = 0;
      else if (cval >= 0) e = cval;
      else e = hist[trig_idx - PRETRIG + cols[i]];
      check($sformatf("col%0d", cols[i]), screenData, e);
    end
  endtask

  task automatic swap_and_check(input bit exp_trig);
    repeat ($urandom_range(1, 4)) tick();
    check("busy_in_done", busy, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("resample_pulse", resample, 1);
    check("triggered", triggered, exp_trig);
    tick();
    check("resample_clear", resample, 0);
    read_cols(-1);
  endtask

  initial begin
    int lat, nres, nbusy;
    nvec = 0; nfail = 0; vcnt = 0; rec = 1'b0; cap_done = 1'b0; trig_idx = -1; tgt = 0;
    screenX = '0; sample_in = '0; decim = 8'd0; trig_level = 12'd2000; trig_slope = 1'b0;

    // Ramp, rising at 2000, normal mode
    do_reset(2'd1);
    check("rst_screenData", screenData, 0);
    check("rst_resample", resample, 0);
    check("rst_triggered", triggered, 0);
    check("rst_busy", busy, 0);
    tick();
    check("busy_prefill", busy, 1);
    start_capture();
    run_capture(0, 1'b0, 0, 4000);
    swap_and_check(1'b1);

    // Random capture aborted by reset mid-POSTFILL
    trig_level = DATA_W'($urandom_range(500, 3500));
    trig_slope = 1'($urandom_range(0, 1));
    start_capture();
    run_capture(2, 1'b0, 100, 4000);
    rec = 1'b0;
    reset = 1'b1; screenX = '0;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_screenData", screenData, 0);
    check("abort_triggered", triggered, 0);
    tick();
    check("abort_col0", screenData, 0);
    start_capture();
    screenX = X_W'(PRETRIG); tick(); check("abort_col64", screenData, 0);
    screenX = X_W'(DEPTH - 1); tick(); check("abort_col639", screenData, 0);
    run_capture(2, 1'b0, 0, 6000);
    swap_and_check(1'b1);

    // Random with decimation; last write coincides with frame_start
    decim = 8'd2;
    trig_level = DATA_W'($urandom_range(500, 3500));
    trig_slope = 1'($urandom_range(0, 1));
    do_reset(2'd3);
    tick();
    start_capture();
    run_capture(2, 1'b1, 0, 9000);
    swap_and_check(1'b1);

    // Falling square wave, decim 3
    decim = 8'd3; trig_level = 12'd1500; trig_slope = 1'b1;
    do_reset(2'd1);
    tick();
    start_capture();
    run_capture(1, 1'b0, 0, 8000);
    swap_and_check(1'b1);

    // Auto mode forces a capture on a flat input
    decim = 8'd0; trig_level = 12'd2000; trig_slope = 1'b0;
    do_reset(2'd0);
    tick();
    lat = 0;
    for (int i = 1; i <= 3000 && lat == 0; i++) begin
      sample_valid = 1'b1; sample_in = 12'd1000; frame_start = 1'b1;
      tick();
      if (resample === 1'b1) lat = i;
    end
    sample_valid = 1'b0; frame_start = 1'b0;
    check("auto_latency_ok", (lat >= 1630 && lat <= 1650), 1);
    check("auto_triggered", triggered, 0);
    read_cols(1000);

    // Same input in normal mode never captures
    do_reset(2'd1);
    nres = 0;
    for (int i = 0; i < 10000; i++) begin
      sample_valid = 1'b1; sample_in = 12'd1000; frame_start = 1'b1;
      tick();
      if (resample === 1'b1) nres++;
    end
    sample_valid = 1'b0; frame_start = 1'b0;
    check("normal_no_resample", nres, 0);
    check("normal_busy", busy, 1);

    // Single mode: idle until armed, exactly one swap per arm
    trig_level = 12'd100;
    do_reset(2'd2);
    nres = 0; nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      sample_valid = 1'b1; sample_in = DATA_W'(i); frame_start = (i % 50 == 49);
      tick();
      if (resample === 1'b1) nres++;
      if (busy !== 1'b0) nbusy++;
    end
    sample_valid = 1'b0; frame_start = 1'b0;
    check("single_unarmed_busy", nbusy, 0);
    check("single_unarmed_resample", nres, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    check("single_armed_busy", busy, 1);
    start_capture();
    run_capture(0, 1'b0, 0, 2000);
    swap_and_check(1'b1);
    nres = 0; nbusy = 0;
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1; sample_in = DATA_W'(i); frame_start = (i % 50 == 49);
      tick();
      if (resample === 1'b1) nres++;
      if (busy !== 1'b0) nbusy++;
    end
    sample_valid = 1'b0; frame_start = 1'b0;
    check("single_rearm_busy", nbusy, 0);
    check("single_rearm_resample", nres, 0);
    arm = 1'b1; tick(); arm = 1'b0;
    start_capture();
    run_capture(0, 1'b0, 0, 2000);
    swap_and_check(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Edge-triggered, double-buffered capture stage between the ADC channel outputs (CH0..CH7, 12-bit) and the display path that indexes samples by screen column (sX).
- Holds a pre-trigger history, then freezes one screen-width frame around the trigger point.
- Presents the frame read-only, indexed by screenX.
- Swaps buffers only at a frame boundary, so the display never tears.

Parameters:
- DATA_W, 12, sample width.
- X_W, 11, screen column index width.
- DEPTH, 640, samples per frame; one per visible column.
- PRETRIG, 64, samples kept before the trigger point; must be less than DEPTH.
- AUTO_TIMEOUT, 1048576, clock cycles in WAIT_TRIG before auto mode forces a capture.

Ports:
- clock  in  1  system clock, 50 MHz domain
- reset  in  1  synchronous, active-high
- sample_in  in  DATA_W  ADC channel sample
- sample_valid  in  1  one-cycle strobe, sample_in valid
- decim  in  8  keep 1 of every decim+1 valid samples
- trig_level  in  DATA_W  trigger threshold, unsigned
- trig_slope  in  1  0 = rising, 1 = falling
- trig_mode  in  2  0 = auto, 1 = normal, 2 = single, 3 = reserved (treated as normal)
- arm  in  1  single-mode arm pulse
- frame_start  in  1  one-cycle pulse at display vertical blank
- screenX  in  X_W  display column being drawn
- screenData  out  DATA_W  captured sample for screenX
- resample  out  1  one-cycle pulse on buffer swap
- triggered  out  1  last swapped frame came from a real edge (0 = auto-forced)
- busy  out  1  high in PREFILL, WAIT_TRIG, POSTFILL

Behaviour:
- Reset values: screenData = 0, resample = 0, triggered = 0, busy = 0, state = IDLE, front_valid = 0, decimation counter = 0.
- Reset mid-capture aborts the capture. Memory contents are don't-care because front_valid gates the output.
- Decimation: counter increments on each sample_valid and wraps at decim. A sample is "kept" when counter == 0. Only kept samples are written or tested. decim = 0 keeps every sample.
- Write pointer wptr runs 0..DEPTH-1 and wraps to 0. Writes go to the back buffer only.
- IDLE:
  - Modes 0/1/3: go to PREFILL next cycle.
  - Mode 2: wait for arm.
  - trig_mode is sampled on leaving IDLE and on leaving DONE.
- PREFILL: write kept samples; go to WAIT_TRIG after PRETRIG writes. This guarantees full history before a trigger.
- WAIT_TRIG:
  - Keep writing circularly. prev = last kept sample.
  - Rising trigger: prev < trig_level and cur >= trig_level.
  - Falling trigger: prev > trig_level and cur <= trig_level.
  - On trigger: base = (wptr_of_cur - PRETRIG) mod DEPTH; set trig_flag = 1; go to POSTFILL.
  - Auto mode: a cycle counter, cleared on entry, reaching AUTO_TIMEOUT forces base = (wptr - PRETRIG) mod DEPTH, trig_flag = 0, go to POSTFILL.
  - trig_level changes apply immediately.
- POSTFILL: the triggering sample counts as write 1. After exactly DEPTH - PRETRIG writes, go to DONE.
- DONE:
  - On frame_start: toggle front_sel, set front_base = base, set triggered = trig_flag, set front_valid = 1, pulse resample for 1 cycle.
  - Then single mode goes to IDLE; other modes go to PREFILL.
  - A frame_start in the same cycle as the final POSTFILL write is not honoured; the swap waits for the next frame_start.
- arm outside IDLE: ignored.
- Read path:
  - addr = (front_base + screenX) mod DEPTH in the front buffer; synchronous RAM; screenData valid 1 cycle after screenX.
  - screenX >= DEPTH or front_valid = 0: screenData = 0.
- Modulo arithmetic: use compare-and-subtract on X_W+1 bits; no divider.

Decomposition:
- Package trigger_pkg:
  - state encodings IDLE, PREFILL, WAIT_TRIG, POSTFILL, DONE;
  - mode constants MODE_AUTO, MODE_NORMAL, MODE_SINGLE;
  - slope constants.
- Sub-module trig_frame_ram:
  - 2*DEPTH x DATA_W, one write port, one synchronous read port.
  - Address = {buffer_sel, index}.
  - Infers M10K.

Test Plan:
- Ramp 0..4095 (step 1, sample_valid every cycle), rising, level 2000, normal, decim 0 -> resample after next frame_start; screenData at screenX=64 is 2000, at 0 is 1936, at 639 is 2575; triggered = 1.
- Constant 1000, level 2000, auto, AUTO_TIMEOUT = 1000 -> capture forced about 1000 cycles after WAIT_TRIG; all columns read 1000; triggered = 0. Same stimulus in normal mode -> no resample for 10000 cycles.
- Falling edge, square wave 3000/500, level 1500, decim 3 -> frame starts 64 kept samples before the 3000->500 transition; adjacent columns are 4 input samples apart.
- Single mode, no arm -> busy = 0 and no writes. Pulse arm -> exactly one resample; a further trigger edge produces no second swap until arm again.
- Reset asserted mid-POSTFILL -> next cycle busy = 0, screenData = 0 for all screenX until a new completed frame swaps in.
- Last POSTFILL write coincident with frame_start -> no resample that cycle; resample on the following frame_start. screenX = 700 -> screenData = 0.
